// File: rtl/sram_burst_reader.sv
// Burst reader: streams `length` consecutive SRAM words from base_addr into a
// 2-entry output FIFO with valid/ready handshake, 1-cycle SRAM read latency.
module sram_burst_reader #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic [ADDR_W-1:0] ReadAddress,
   input  logic [DATA_W-1:0] ReadBus,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t              r_state, w_next;
   logic [ADDR_W-1:0]   r_addr, r_next_addr;
   logic [ADDR_W:0]     r_remain;
   logic                r_inflight;
   logic [1:0]          r_count;
   logic [DATA_W-1:0]   r_mem [2];
   logic                r_rd_ptr, r_wr_ptr;

   logic                w_pop, w_issue;
   logic [2:0]          w_occ;

   assign w_pop   = (r_count != 2'd0) && out_ready;
   // Words held or already requested, net of this cycle's pop; pop implies count>=1.
   assign w_occ   = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
   assign w_issue = (r_state == ISSUE) && (w_occ < 3'd2);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (start) w_next = (length == '0) ? DONE : ISSUE;
         ISSUE: if (w_issue && r_remain == (ADDR_W+1)'(1)) w_next = DRAIN;
         DRAIN: if (!r_inflight && r_count == 2'd0) w_next = DONE;
         DONE:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_next_addr <= '0;
         r_remain    <= '0;
         r_inflight  <= 1'b0;
         r_count     <= 2'd0;
         r_rd_ptr    <= 1'b0;
         r_wr_ptr    <= 1'b0;
         for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && start) begin
            r_next_addr <= base_addr;
            r_remain    <= length;
         end
         if (w_issue) begin
            r_addr      <= r_next_addr;
            r_next_addr <= r_next_addr + 1'b1;
            r_remain    <= r_remain - 1'b1;
         end
         r_inflight <= w_issue;
         // The word requested last cycle is on ReadBus now.
         if (r_inflight) begin
            r_mem[r_wr_ptr] <= ReadBus;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
      end
   end

   assign ReadAddress = r_addr;
   assign out_data    = r_mem[r_rd_ptr];
   assign out_valid   = (r_count != 2'd0);
   assign busy        = (r_state == ISSUE) || (r_state == DRAIN);
   assign done        = (r_state == DONE);

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader: table of bursts with hand-computed
// first/last words, plus zero-length and mid-burst reset sequences.
module tb_sram_burst_reader;
   localparam int AW = 14;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          reset, start, out_ready;
   logic [AW-1:0] base_addr, ReadAddress;
   logic [AW:0]   length;
   logic [DW-1:0] ReadBus, out_data;
   logic          out_valid, busy, done;

   always #5 clock = ~clock;

   sram_burst_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
      .length(length), .ReadAddress(ReadAddress), .ReadBus(ReadBus),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   // SRAM contents: A0..A3 at 100..103, otherwise address ^ 5A00.
   function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
      if (a >= 14'd100 && a <= 14'd103) return 16'h00A0 + 16'(a - 14'd100);
      return 16'(a) ^ 16'h5A00;
   endfunction
   assign ReadBus = sram_word(ReadAddress);

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   len;
      int            mode;     // 0 ready=1, 1 ready 1,0,0 repeating, 2 random
      bit            restart;  // pulse a second start mid-burst
      logic [DW-1:0] first;
      logic [DW-1:0] last;
      bit            chk_addr;
   } vec_t;

   int            res_words, res_dones, res_span, res_order_err, res_stall_err;
   bit            res_timeout;
   logic          res_busy_after;
   logic [DW-1:0] res_first, res_last;
   logic [AW-1:0] addr_q[$];

   task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] len,
                            input int mode, input bit restart);
      int cyc = 0, first_t = -1, last_t = -1;
      bit seen_done = 0;
      logic pv = 0, pr = 0;
      logic [DW-1:0] pd = '0;
      logic [AW-1:0] pa;
      res_words = 0; res_dones = 0; res_order_err = 0; res_stall_err = 0;
      res_first = 'x; res_last = 'x; res_timeout = 0;
      addr_q.delete();
      @(negedge clock);
      start = 1; base_addr = base; length = len; out_ready = 0;
      pa = ReadAddress;
      @(negedge clock);
      while (!seen_done && cyc < 400) begin
         if (restart && cyc == 3) begin
            start = 1; base_addr = 14'd900; length = 15'd3;
         end else start = 0;
         case (mode)
            0: out_ready = 1;
            1: out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (ReadAddress !== pa) begin addr_q.push_back(ReadAddress); pa = ReadAddress; end
         if (pv && !pr && (!out_valid || out_data !== pd)) res_stall_err++;
         if (out_valid && out_ready) begin
            if (out_data !== sram_word(AW'(base + AW'(res_words)))) res_order_err++;
            if (first_t < 0) begin first_t = cyc; res_first = out_data; end
            last_t = cyc; res_last = out_data;
            res_words++;
         end
         if (done) begin res_dones++; seen_done = 1; end
         pv = out_valid; pd = out_data; pr = out_ready;
         cyc++;
         @(negedge clock);
      end
      start = 0;
      #1;
      if (done) res_dones++;
      res_busy_after = busy;
      res_timeout = !seen_done;
      res_span = last_t - first_t;
   endtask

   vec_t vecs[6];

   initial begin
      int xfers;
      logic [AW-1:0] pa;
      vecs[0] = '{14'd100,   15'd4,  0, 0, 16'h00A0, 16'h00A3, 0};
      vecs[1] = '{14'd16382, 15'd4,  0, 0, 16'h65FE, 16'h5A01, 1};
      vecs[2] = '{14'd200,   15'd8,  1, 0, 16'h5AC8, 16'h5ACF, 0};
      vecs[3] = '{14'd40,    15'd6,  0, 1, 16'h5A28, 16'h5A2D, 0};
      vecs[4] = '{14'd500,   15'd10, 2, 0, 16'h5BF4, 16'h5BFD, 0};
      vecs[5] = '{14'd7,     15'd1,  1, 0, 16'h5A07, 16'h5A07, 0};

      reset = 1; start = 0; base_addr = '0; length = '0; out_ready = 0;
      repeat (2) @(negedge clock);
      chk("rst_addr", 32'(ReadAddress), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      reset = 0;

      foreach (vecs[i]) begin
         run_burst(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].restart);
         chk($sformatf("v%0d_timeout", i), 32'(res_timeout), 0);
         chk($sformatf("v%0d_words", i), 32'(res_words), 32'(vecs[i].len));
         chk($sformatf("v%0d_first", i), 32'(res_first), 32'(vecs[i].first));
         chk($sformatf("v%0d_last", i), 32'(res_last), 32'(vecs[i].last));
         chk($sformatf("v%0d_order", i), 32'(res_order_err), 0);
         chk($sformatf("v%0d_stall", i), 32'(res_stall_err), 0);
         chk($sformatf("v%0d_dones", i), 32'(res_dones), 1);
         chk($sformatf("v%0d_busy_after", i), 32'(res_busy_after), 0);
         if (vecs[i].mode == 0)
            chk($sformatf("v%0d_span", i), 32'(res_span), 32'(vecs[i].len) - 1);
         if (vecs[i].chk_addr) begin
            chk($sformatf("v%0d_naddr", i), 32'(addr_q.size()), 32'(vecs[i].len));
            foreach (addr_q[k])
               chk($sformatf("v%0d_addr%0d", i, k), 32'(addr_q[k]),
                   32'(AW'(vecs[i].base + AW'(k))));
         end
      end

      // Zero-length burst: no read, done one cycle after acceptance.
      @(negedge clock);
      pa = ReadAddress;
      start = 1; base_addr = 14'd77; length = '0; out_ready = 1;
      @(negedge clock); start = 0; #1;
      chk("z_done", 32'(done), 1);
      chk("z_valid", 32'(out_valid), 0);
      chk("z_addr", 32'(ReadAddress), 32'(pa));
      @(negedge clock); #1;
      chk("z_done_off", 32'(done), 0);
      chk("z_busy", 32'(busy), 0);
      chk("z_valid2", 32'(out_valid), 0);
      chk("z_addr2", 32'(ReadAddress), 32'(pa));

      // Mid-burst reset after 5 words.
      @(negedge clock);
      start = 1; base_addr = 14'd300; length = 15'd16; out_ready = 1;
      @(negedge clock); start = 0;
      xfers = 0;
      for (int c = 0; c < 100 && xfers < 5; c++) begin
         #1;
         if (out_valid && out_ready) xfers++;
         @(negedge clock);
      end
      chk("mr_xfers", 32'(xfers), 5);
      chk("mr_busy_before", 32'(busy), 1);
      reset = 1;
      @(negedge clock); #1;
      reset = 0;
      chk("mr_addr", 32'(ReadAddress), 0);
      chk("mr_valid", 32'(out_valid), 0);
      chk("mr_data", 32'(out_data), 0);
      chk("mr_busy", 32'(busy), 0);
      chk("mr_done", 32'(done), 0);
      xfers = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock); #1;
         if (done || out_valid || busy) xfers++;
      end
      chk("mr_quiet", 32'(xfers), 0);
      run_burst(14'd0, 15'd2, 0, 0);
      chk("mr2_timeout", 32'(res_timeout), 0);
      chk("mr2_words", 32'(res_words), 2);
      chk("mr2_first", 32'(res_first), 32'h5A00);
      chk("mr2_last", 32'(res_last), 32'h5A01);
      chk("mr2_dones", 32'(res_dones), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sram_burst_reader.md
SRAM_BURST_READER -- requirements
Module: sram_burst_reader

Interface
REQ-001: The block SHALL have parameter ADDR_W, default 14, SRAM word-address width.
REQ-002: The block SHALL have parameter DATA_W, default 16, SRAM word width.
REQ-003: The block SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-004: The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005: The block SHALL have port start, input, 1, burst request, sampled only in IDLE.
REQ-006: The block SHALL have port base_addr, input, ADDR_W, first word address, captured on accepted start.
REQ-007: The block SHALL have port length, input, ADDR_W+1, word count 0..2^ADDR_W, captured on accepted start.
REQ-008: The block SHALL have port ReadAddress, output, ADDR_W, registered address to the SRAM 1R1W read port.
REQ-009: The block SHALL have port ReadBus, input, DATA_W, SRAM read data, valid at the rising edge after ReadAddress changes.
REQ-010: The block SHALL have port out_data, output, DATA_W, head word of the output buffer.
REQ-011: The block SHALL have port out_valid, output, 1, out_data holds a valid word.
REQ-012: The block SHALL have port out_ready, input, 1, consumer accepts; a transfer occurs on a cycle with out_valid and out_ready both high.
REQ-013: The block SHALL have port busy, output, 1, high from accepted start until done.
REQ-014: The block SHALL have port done, output, 1, one-cycle pulse at burst completion.

Function
REQ-015: The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-016: In IDLE with start=1 and length>0, it SHALL capture base_addr and length and enter ISSUE; busy goes high the next cycle.
REQ-017: In IDLE with start=1 and length=0, it SHALL enter DONE with no SRAM read; done pulses exactly one cycle later.
REQ-018: A start while not in IDLE SHALL be ignored with no effect on the current burst.
REQ-019: An issue in ISSUE SHALL load ReadAddress with the next address and set an in-flight flag; the word on ReadBus is written into the output buffer at the following rising edge (1-cycle read latency).
REQ-020: The output buffer SHALL be a 2-entry FIFO, FIFO order, with count 0..2.
REQ-021: An issue SHALL be permitted only when count + inflight - pop < 2, where pop = out_valid & out_ready in the same cycle, so the buffer never overflows.
REQ-022: With out_ready held high, the block SHALL sustain one word per cycle after the first word.
REQ-023: Addresses SHALL increment by 1 modulo 2^ADDR_W, so 16383 wraps to 0.
REQ-024: After the last of length issues, it SHALL enter DRAIN and stay until inflight=0 and count=0.
REQ-025: DRAIN SHALL then go to DONE; DONE asserts done for one cycle, deasserts busy, and returns to IDLE.
REQ-026: out_valid SHALL equal (count>0); out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-027: A simultaneous buffer write and pop SHALL leave count unchanged and preserve order.
REQ-028: Exactly length words SHALL be delivered per burst, with no duplicates or drops under any out_ready pattern.
REQ-029: ReadAddress SHALL hold its value between issues.

Reset
REQ-030: On reset=1 at a rising edge, the FSM SHALL go to IDLE, count and inflight clear, ReadAddress=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-031: A reset mid-burst SHALL abandon the burst with no done pulse, discard buffered and in-flight data, and allow a new start on the first cycle after reset releases.

Verification
REQ-032: With SRAM[100..103]=A0,A1,A2,A3, out_ready=1, start, base=100, len=4 -> out_data A0..A3 on 4 consecutive valid cycles; done pulses once; busy is low the cycle after.
REQ-033: With base=16382, len=4 -> ReadAddress sequence 16382, 16383, 0, 1; data is delivered in that order.
REQ-034: With len=8 and out_ready toggling 1,0,0,1,... -> all 8 words delivered in order; count never exceeds 2; out_data is stable during stalls.
REQ-035: With start, len=0 -> no ReadAddress change, out_valid stays 0, and done pulses once.
REQ-036: With len=16 and reset asserted after 5 words -> all outputs reach reset values next cycle, with no done; a new burst base=0, len=2 then completes correctly.
REQ-037: With start pulsed during an active burst of len=6 -> the second start is ignored; exactly 6 words are delivered and one done pulse occurs.
